gate_sweep_checker: RTL and testbench

//  Self-checking stimulus/response stage for the small combinational gate blocks
//  (NOR, NAND, XOR, ...). Upstream: drives the gate inputs through every input

---
 rtl/gate_sweep_checker.sv | 136 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// Sweeps a small gate through every input vector and checks its output
// against a parameterised truth table, reporting mismatch statistics.
module gate_sweep_checker #(
    parameter int                    N_IN   = 2,
    parameter int                    DWELL  = 10,
    parameter logic [(2**N_IN)-1:0]  EXP_TT = 4'b0001,
    parameter int                    ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_y,
    output logic [N_IN-1:0]  vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_vld
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [N_IN-1:0]  VEC_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  fvec_q, fvec_d;
    logic             fvld_q, fvld_d;
    logic             mismatch;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvld_d   = fvld_q;
        mismatch = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                vec_d = '0;
                cnt_d = '0;
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fvec_d  = '0;
                    fvld_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // Case inequality so an undriven output never passes.
                    mismatch = (dut_y !== EXP_TT[vec_q]);
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fvld_q) begin
                            fvec_d = vec_q;
                            fvld_d = 1'b1;
                        end
                    end
                    cnt_d = '0;
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                        vec_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            fvld_q  <= fvld_d;
        end
    end

    assign vec_out       = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign first_err_vec = fvec_q;
    assign first_err_vld = fvld_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: random truth tables drive the gate input, a table-level
// model predicts each sweep's verdict, a monitor checks every done pulse.
module tb_gate_sweep_checker;

    localparam int DW  = 10;
    localparam int NV  = 4;
    localparam int DW2 = 3;
    localparam int NV2 = 8;

    typedef struct {
        int pass;
        int err;
        int fvec;
        int fvld;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dut_y;
    logic [3:0] tt = 4'b0001;
    logic [1:0] vec_out;
    logic       busy, done, pass, fvld;
    logic [7:0] err_cnt;
    logic [1:0] fvec;

    logic       start2 = 1'b0;
    logic       y2;
    logic [7:0] tt2 = 8'hff;
    logic [2:0] vec2;
    logic       busy2, done2, pass2, fvld2;
    logic [1:0] err2;
    logic [2:0] fvec2;

    int   total = 0;
    int   bad = 0;
    int   run_cyc = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    assign dut_y = tt[vec_out];
    assign y2    = tt2[vec2];

    gate_sweep_checker #(
        .N_IN(2), .DWELL(DW), .EXP_TT(4'b0001), .ERR_W(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_y(dut_y),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_vec(fvec), .first_err_vld(fvld)
    );

    gate_sweep_checker #(
        .N_IN(3), .DWELL(DW2), .EXP_TT(8'h00), .ERR_W(2)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_y(y2),
        .vec_out(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .first_err_vec(fvec2), .first_err_vld(fvld2)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d @%0t", name, act, req, $time);
        end
    endtask

    // Verdict straight from the tables: count differing entries.
    function automatic exp_t model(input logic [7:0] got, input logic [7:0] want,
                                   input int nvec, input int maxerr);
        exp_t e;
        int   n = 0;
        e.fvld = 0;
        e.fvec = 0;
        for (int v = 0; v < nvec; v++) begin
            if (got[v] != want[v]) begin
                n++;
                if (e.fvld == 0) begin
                    e.fvld = 1;
                    e.fvec = v;
                end
            end
        end
        e.err  = (n > maxerr) ? maxerr : n;
        e.pass = (n == 0) ? 1 : 0;
        return e;
    endfunction

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            run_cyc = 0;
        end else if (busy) begin
            chk("vec_seq", int'(vec_out), run_cyc / DW);
            chk("done_in_run", int'(done), 0);
            run_cyc++;
        end else if (done) begin
            chk("sweep_len", run_cyc, NV * DW);
            chk("vec_at_done", int'(vec_out), 0);
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("pass", int'(pass), e.pass);
                chk("err_cnt", int'(err_cnt), e.err);
                chk("first_err_vld", int'(fvld), e.fvld);
                if (e.fvld != 0) chk("first_err_vec", int'(fvec), e.fvec);
            end
            run_cyc = 0;
        end else begin
            run_cyc = 0;
        end
    end

    task automatic sweep(input logic [3:0] t, input bit held, input bit keep);
        exp_t e;
        int   w;
        if (!held) repeat (2) @(negedge clk);
        tt = t;
        e = model({4'b0, t}, 8'h01, NV, 255);
        sbq.push_back(e);
        if (!held) start = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!busy && w < 4);
        chk("launch_lat", w, held ? 2 : 1);
        chk("err_clear", int'(err_cnt), 0);
        chk("fvld_clear", int'(fvld), 0);
        if (!keep) begin
            start = 1'b0;
            repeat ($urandom_range(1, 30)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        w = 0;
        while (!done && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!done) chk("done_timeout", 0, 1);
        if (!keep) begin
            @(negedge clk);
            chk("pass_hold", int'(pass), e.pass);
            chk("err_hold", int'(err_cnt), e.err);
        end
    endtask

    task automatic reset_mid_sweep();
        int w = 0;
        int nd = 0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (vec_out != 2'd2 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("reach_vec2", int'(vec_out), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vec", int'(vec_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_flags", int'({done, pass, fvld, fvec}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_reset", nd, 0);
    endtask

    task automatic sweep3(input logic [7:0] t);
        exp_t e;
        int   w = 0;
        int   nb = 0;
        tt2 = t;
        e = model(t, 8'h00, NV2, 3);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        while (!done2 && w < 100) begin
            if (busy2) nb++;
            @(negedge clk);
            w++;
        end
        if (!done2) chk("done3_timeout", 0, 1);
        chk("len3", nb, NV2 * DW2);
        chk("err3", int'(err2), e.err);
        chk("pass3", int'(pass2), e.pass);
        chk("fvld3", int'(fvld2), e.fvld);
        if (e.fvld != 0) chk("fvec3", int'(fvec2), e.fvec);
    endtask

    initial begin
        #1;
        chk("reset_vec", int'(vec_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err_cnt), 0);
        chk("reset_flags", int'({pass, fvld, fvec}), 0);
        #20 rst_n = 1'b1;

        sweep(4'b0001, 1'b0, 1'b0);
        sweep(4'b0000, 1'b0, 1'b0);
        sweep(4'b0111, 1'b0, 1'b0);
        reset_mid_sweep();
        sweep(4'b0001, 1'b0, 1'b1);
        sweep(4'b1110, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            sweep(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end

        sweep3(8'hff);
        sweep3(8'h00);
        sweep3(8'($urandom_range(0, 255)));
        sweep3(8'h90);

        repeat (5) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
